// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the LC-3b pipeline hazard controller.
// Imported by the interface, scoreboard and top.
package pipeline_hazard_ctrl_pkg;

  localparam int NUM_STAGES_DEFAULT = 5;
  localparam int NUM_REGS_DEFAULT   = 8;
  localparam int CNT_W_DEFAULT      = 16;

  typedef enum logic {
    RUN      = 1'b0,
    DRAIN_IF = 1'b1
  } lc3b_hz_state;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle.
// master = datapath side, slave = controller side.
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter int NUM_REGS   = NUM_REGS_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
);
  localparam int NREG  = NUM_STAGES - 1;
  localparam int REG_W = $clog2(NUM_REGS);

  logic             if_memread;
  logic             if_mem_resp;
  logic             mem_memread;
  logic             mem_memwrite;
  logic             mem_mem_resp;
  logic             mem_indirect;
  logic [REG_W-1:0] id_sr1;
  logic [REG_W-1:0] id_sr2;
  logic             id_sr1_used;
  logic             id_sr2_used;
  logic [REG_W-1:0] id_dr;
  logic             id_writes_dr;
  logic [REG_W-1:0] wb_dr;
  logic             wb_load_regfile;
  logic             wb_flush;

  logic             pc_stall;
  logic [NREG-1:0]  reg_stall;
  logic [NREG-1:0]  reg_bubble;
  logic [NREG-1:0]  stage_valid;
  logic             redirect_capture;
  logic             redirect_apply;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_memread, if_mem_resp,
    output mem_memread, mem_memwrite,
    output mem_mem_resp, mem_indirect,
    output id_sr1, id_sr2,
    output id_sr1_used, id_sr2_used,
    output id_dr, id_writes_dr,
    output wb_dr, wb_load_regfile, wb_flush,
    input  pc_stall, reg_stall, reg_bubble,
    input  stage_valid,
    input  redirect_capture, redirect_apply,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  if_memread, if_mem_resp,
    input  mem_memread, mem_memwrite,
    input  mem_mem_resp, mem_indirect,
    input  id_sr1, id_sr2,
    input  id_sr1_used, id_sr2_used,
    input  id_dr, id_writes_dr,
    input  wb_dr, wb_load_regfile, wb_flush,
    output pc_stall, reg_stall, reg_bubble,
    output stage_valid,
    output redirect_capture, redirect_apply,
    output stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sb.sv
// RAW scoreboard: one in-flight writer count per
// architectural register, two read ports.
module hz_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter int NUM_REGS   = NUM_REGS_DEFAULT,
  parameter int REG_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             issue_i,
  input  logic [REG_W-1:0] issue_idx_i,
  input  logic             retire_i,
  input  logic [REG_W-1:0] retire_idx_i,
  input  logic [REG_W-1:0] rd0_idx_i,
  input  logic [REG_W-1:0] rd1_idx_i,
  output logic             rd0_busy_o,
  output logic             rd1_busy_o
);
  localparam int CW = $clog2(NUM_STAGES) + 1;

  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_i) begin
        cnt_d[i] = '0;
      end else if (issue_i && issue_idx_i == REG_W'(i)
                   && !(retire_i && retire_idx_i == REG_W'(i))) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (retire_i && retire_idx_i == REG_W'(i)
                   && !(issue_i && issue_idx_i == REG_W'(i))) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd0_busy_o = (cnt_q[rd0_idx_i] != '0);
  assign rd1_busy_o = (cnt_q[rd1_idx_i] != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / bubble / flush controller for the LC-3b pipeline,
// with safe redirect while an I-fetch is outstanding.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter int NUM_REGS   = NUM_REGS_DEFAULT,
  parameter int REG_W      = $clog2(NUM_REGS),
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int NREG = NUM_STAGES - 1;

  lc3b_hz_state state_q, state_d;
  logic [NREG-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_busy, if_busy, raw_hz;
  logic sr1_busy, sr2_busy;
  logic in_run, in_drain;
  logic run_mem, run_flush, run_raw, run_fetch;
  logic issue, retire;

  logic            pc_stall_c;
  logic [NREG-1:0] stall_c;
  logic [NREG-1:0] bubble_c;
  logic            capture_c;
  logic            apply_c;

  assign mem_busy = ((hz.mem_memread | hz.mem_memwrite)
                     & ~hz.mem_mem_resp) | hz.mem_indirect;
  assign if_busy  = hz.if_memread & ~hz.if_mem_resp;
  assign raw_hz   = valid_q[0]
                  & ((hz.id_sr1_used & sr1_busy)
                   | (hz.id_sr2_used & sr2_busy));

  // One-hot decode of the RUN priority chain
  assign in_run    = (state_q == RUN);
  assign in_drain  = (state_q == DRAIN_IF);
  assign run_mem   = in_run & mem_busy;
  assign run_flush = in_run & ~mem_busy
                   & hz.wb_flush & valid_q[NREG-1];
  assign run_raw   = in_run & ~mem_busy & ~run_flush & raw_hz;
  assign run_fetch = in_run & ~mem_busy & ~run_flush
                   & ~raw_hz & if_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (run_flush && if_busy) state_d = DRAIN_IF;
      DRAIN_IF: if (hz.if_mem_resp)       state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    pc_stall_c = 1'b0;
    stall_c    = '0;
    bubble_c   = '0;
    capture_c  = 1'b0;
    apply_c    = 1'b0;
    unique case (1'b1)
      in_drain: begin
        bubble_c[0] = 1'b1;
        pc_stall_c  = ~hz.if_mem_resp;
        apply_c     = hz.if_mem_resp;
      end
      run_mem: begin
        pc_stall_c = 1'b1;
        stall_c    = '1;
      end
      run_flush: begin
        bubble_c   = '1;
        pc_stall_c = if_busy;
        capture_c  = if_busy;
      end
      run_raw: begin
        pc_stall_c  = 1'b1;
        stall_c[0]  = 1'b1;
        bubble_c[1] = 1'b1;
      end
      run_fetch: begin
        pc_stall_c  = 1'b1;
        bubble_c[0] = 1'b1;
      end
      default: ;
    endcase
  end

  assign issue  = valid_q[0] & hz.id_writes_dr
                & ~stall_c[0] & ~bubble_c[1];
  assign retire = valid_q[NREG-1] & hz.wb_load_regfile
                & ~stall_c[NREG-1];

  hz_scoreboard #(
    .NUM_STAGES (NUM_STAGES),
    .NUM_REGS   (NUM_REGS),
    .REG_W      (REG_W)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (run_flush),
    .issue_i      (issue),
    .issue_idx_i  (hz.id_dr),
    .retire_i     (retire),
    .retire_idx_i (hz.wb_dr),
    .rd0_idx_i    (hz.id_sr1),
    .rd1_idx_i    (hz.id_sr2),
    .rd0_busy_o   (sr1_busy),
    .rd1_busy_o   (sr2_busy)
  );

  always_comb begin
    valid_d[0] = bubble_c[0] ? 1'b0
               : stall_c[0]  ? valid_q[0]
               : (hz.if_mem_resp & in_run);
    for (int r = 1; r < NREG; r++) begin
      valid_d[r] = bubble_c[r] ? 1'b0
                 : stall_c[r]  ? valid_q[r]
                 : valid_q[r-1];
    end
    stall_cyc_d = stall_cyc_q;
    if (pc_stall_c && !(&stall_cyc_q))
      stall_cyc_d = stall_cyc_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (run_flush && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset forces every pipeline register to load a bubble
  assign hz.pc_stall         = rst_n & pc_stall_c;
  assign hz.reg_stall        = stall_c & {NREG{rst_n}};
  assign hz.reg_bubble       = bubble_c | {NREG{~rst_n}};
  assign hz.redirect_capture = rst_n & capture_c;
  assign hz.redirect_apply   = rst_n & apply_c;
  assign hz.stage_valid      = valid_q;
  assign hz.stall_cycles     = stall_cyc_q;
  assign hz.flush_count      = flush_cnt_q;

  a_no_flush_in_drain: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(in_drain && hz.wb_flush)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised bench for pipeline_hazard_ctrl: an instruction-level
// pipeline model predicts every output, a monitor compares.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int NS   = 5;
  localparam int NR   = 8;
  localparam int CW   = 4;
  localparam int NREG = NS - 1;
  localparam int RW   = 3;
  localparam int CMAX = (1 << CW) - 1;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(
    .NUM_STAGES (NS), .NUM_REGS (NR), .CNT_W (CW)
  ) hz ();

  pipeline_hazard_ctrl #(
    .NUM_STAGES (NS), .NUM_REGS (NR),
    .REG_W (RW), .CNT_W (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    bit v;
    bit wr;
    int dr;
    int s1;
    int s2;
    bit u1;
    bit u2;
  } instr_t;

  typedef struct {
    bit            pc;
    bit [NREG-1:0] st;
    bit [NREG-1:0] bub;
    bit [NREG-1:0] sv;
    bit            cap;
    bit            app;
    int            sc;
    int            fc;
  } exp_t;

  instr_t pipe [NREG];
  bit     drain;
  int     sc_m, fc_m;
  exp_t   expq [$];
  int     errs = 0;
  int     chks = 0;

  function automatic instr_t nop();
    instr_t i;
    i = '{v: 0, wr: 0, dr: 0, s1: 0, s2: 0, u1: 0, u2: 0};
    return i;
  endfunction

  function automatic instr_t fetch_new();
    instr_t i;
    i.v  = 1'b1;
    i.wr = ($urandom % 3) != 0;
    i.dr = $urandom % NR;
    i.s1 = $urandom % NR;
    i.s2 = $urandom % NR;
    i.u1 = ($urandom % 4) != 0;
    i.u2 = ($urandom % 2) != 0;
    return i;
  endfunction

  // Writers still in flight past IF/ID targeting register x
  function automatic int writers(int x);
    int n = 0;
    for (int k = 1; k < NREG; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].dr == x) n++;
    return n;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NREG; k++) pipe[k] = nop();
    drain = 1'b0;
    sc_m  = 0;
    fc_m  = 0;
  endfunction

  task automatic chk(string nm, int act, int req);
    chks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, req);
    end
  endtask

  task automatic step(bit rst_now);
    bit   ifr, ifp, mr, mw, mp, mi, fl, mb, ib, raw;
    exp_t e;
    ifr = ($urandom % 2) != 0;
    ifp = ifr && (($urandom % 2) != 0);
    mr  = ($urandom % 5) == 0;
    mw  = ($urandom % 8) == 0;
    mp  = ($urandom % 2) != 0;
    mi  = ($urandom % 20) == 0;
    fl  = !drain && (($urandom % 5) == 0);

    hz.if_memread      = ifr;
    hz.if_mem_resp     = ifp;
    hz.mem_memread     = mr;
    hz.mem_memwrite    = mw;
    hz.mem_mem_resp    = mp;
    hz.mem_indirect    = mi;
    hz.id_sr1          = RW'(pipe[0].s1);
    hz.id_sr2          = RW'(pipe[0].s2);
    hz.id_sr1_used     = pipe[0].u1;
    hz.id_sr2_used     = pipe[0].u2;
    hz.id_dr           = RW'(pipe[0].dr);
    hz.id_writes_dr    = pipe[0].wr;
    hz.wb_dr           = RW'(pipe[NREG-1].dr);
    hz.wb_load_regfile = pipe[NREG-1].wr;
    hz.wb_flush        = fl;
    rst_n              = !rst_now;
    #1;

    e.pc  = 0; e.st = '0; e.bub = '0;
    e.cap = 0; e.app = 0;
    for (int k = 0; k < NREG; k++) e.sv[k] = pipe[k].v;
    e.sc = sc_m;
    e.fc = fc_m;

    if (rst_now) begin
      e.sv  = '0;
      e.bub = '1;
      e.sc  = 0;
      e.fc  = 0;
      model_reset();
    end else begin
      mb = ((mr || mw) && !mp) || mi;
      ib = ifr && !ifp;
      if (drain) begin
        e.bub[0] = 1'b1;
        e.pc     = !ifp;
        e.app    = ifp;
        for (int k = NREG-1; k >= 1; k--) pipe[k] = pipe[k-1];
        pipe[0] = nop();
        drain   = !ifp;
      end else if (mb) begin
        e.pc = 1'b1;
        e.st = '1;
      end else if (fl && pipe[NREG-1].v) begin
        e.bub = '1;
        e.pc  = ib;
        e.cap = ib;
        for (int k = 0; k < NREG; k++) pipe[k] = nop();
        drain = ib;
        if (fc_m < CMAX) fc_m++;
      end else begin
        raw = pipe[0].v
           && ((pipe[0].u1 && writers(pipe[0].s1) > 0)
            || (pipe[0].u2 && writers(pipe[0].s2) > 0));
        if (raw) begin
          e.pc     = 1'b1;
          e.st[0]  = 1'b1;
          e.bub[1] = 1'b1;
          for (int k = NREG-1; k >= 2; k--) pipe[k] = pipe[k-1];
          pipe[1] = nop();
        end else begin
          e.pc     = ib;
          e.bub[0] = ib;
          for (int k = NREG-1; k >= 1; k--) pipe[k] = pipe[k-1];
          pipe[0] = (!ib && ifp) ? fetch_new() : nop();
        end
      end
      if (e.pc && sc_m < CMAX) sc_m++;
    end
    expq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pc_stall", int'(hz.pc_stall), int'(e.pc));
        chk("reg_stall", int'(hz.reg_stall), int'(e.st));
        chk("reg_bubble", int'(hz.reg_bubble), int'(e.bub));
        chk("stage_valid", int'(hz.stage_valid), int'(e.sv));
        chk("redirect_capture", int'(hz.redirect_capture),
            int'(e.cap));
        chk("redirect_apply", int'(hz.redirect_apply),
            int'(e.app));
        chk("stall_cycles", int'(hz.stall_cycles), e.sc);
        chk("flush_count", int'(hz.flush_count), e.fc);
      end
    end
  end

  initial begin : driver
    bit rst_prev;
    bit rst_now;
    hz.if_memread = 0; hz.if_mem_resp = 0;
    hz.mem_memread = 0; hz.mem_memwrite = 0;
    hz.mem_mem_resp = 0; hz.mem_indirect = 0;
    hz.id_sr1 = '0; hz.id_sr2 = '0;
    hz.id_sr1_used = 0; hz.id_sr2_used = 0;
    hz.id_dr = '0; hz.id_writes_dr = 0;
    hz.wb_dr = '0; hz.wb_load_regfile = 0;
    hz.wb_flush = 0;
    model_reset();
    rst_prev = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c < 3)         rst_now = 1'b1;
      else if (rst_prev) rst_now = 1'b0;
      else if (drain)    rst_now = ($urandom % 4) == 0;
      else               rst_now = ($urandom % 400) == 0;
      step(rst_now);
      rst_prev = rst_now;
    end
    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
